// File: rtl/awb_gain_calc.sv
// Gray-world AWB gain generator: per-frame R/G/B sums, then a shared serial
// divider produces R and B gains relative to G in fi(0,20,12).
module awb_gain_calc #(
    parameter logic [19:0] GAIN_MAX = 20'h04000,
    parameter logic [19:0] GAIN_MIN = 20'h00400
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_enable,
    input  logic        I_rgb888_frame_start,
    input  logic        I_rgb888_frame_end,
    input  logic        I_rgb888_valid,
    input  logic [95:0] I_rgb888_data,
    output logic [19:0] O_r_gain,
    output logic [19:0] O_g_gain,
    output logic [19:0] O_b_gain,
    output logic        O_gain_update,
    output logic        O_busy
);

    typedef enum logic [1:0] {IDLE, DIV_R, DIV_B, UPDATE} state_t;
    state_t state, state_n;

    logic [9:0]  beat_r, beat_g, beat_b;
    logic [31:0] sum_r, sum_g, sum_b;
    logic [31:0] sum_r_x, sum_g_x, sum_b_x;
    logic [31:0] snap_r, snap_g, snap_b;
    logic [31:0] rem, den, rem_nx;
    logic [43:0] num, quo_nx;
    logic [32:0] rem_sh, diff;
    logic [5:0]  cnt;
    logic [19:0] r_res, b_res;
    logic        ge, last, start, div_step, res_load, pend;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [9:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {23'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    function automatic logic [19:0] gain_of(input logic [43:0] q, input logic [31:0] d,
                                            input logic [31:0] g);
        if (d == '0)
            return (g == '0) ? 20'h01000 : GAIN_MAX;
        if (q > {24'b0, GAIN_MAX})
            return GAIN_MAX;
        if (q < {24'b0, GAIN_MIN})
            return GAIN_MIN;
        return q[19:0];
    endfunction

    always_comb begin
        beat_r = '0;
        beat_g = '0;
        beat_b = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            beat_r = beat_r + {2'b00, I_rgb888_data[95 - 24*i -: 8]};
            beat_g = beat_g + {2'b00, I_rgb888_data[87 - 24*i -: 8]};
            beat_b = beat_b + {2'b00, I_rgb888_data[79 - 24*i -: 8]};
        end
    end

    // Running sum including this cycle's beat; feeds both accumulation and snapshot.
    assign sum_r_x = I_rgb888_valid ? sat_add(sum_r, beat_r) : sum_r;
    assign sum_g_x = I_rgb888_valid ? sat_add(sum_g, beat_g) : sum_g;
    assign sum_b_x = I_rgb888_valid ? sat_add(sum_b, beat_b) : sum_b;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            sum_r <= '0;
            sum_g <= '0;
            sum_b <= '0;
        end else if (I_rgb888_frame_start) begin
            sum_r <= I_rgb888_valid ? {22'b0, beat_r} : '0;
            sum_g <= I_rgb888_valid ? {22'b0, beat_g} : '0;
            sum_b <= I_rgb888_valid ? {22'b0, beat_b} : '0;
        end else begin
            sum_r <= sum_r_x;
            sum_g <= sum_g_x;
            sum_b <= sum_b_x;
        end
    end

    assign start  = (state == IDLE) && !O_busy && I_enable && I_rgb888_frame_end;
    assign last   = (cnt == 6'd43);
    assign den    = (state == DIV_R) ? snap_r : snap_b;
    assign rem_sh = {rem, num[43]};
    assign diff   = rem_sh - {1'b0, den};
    assign ge     = (rem_sh >= {1'b0, den});
    assign rem_nx = ge ? diff[31:0] : rem_sh[31:0];
    assign quo_nx = {num[42:0], ge};

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = DIV_R;
            DIV_R:   if (last)  state_n = DIV_B;
            DIV_B:   if (last)  state_n = UPDATE;
            UPDATE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        div_step = (state == DIV_R) || (state == DIV_B);
        res_load = (state == UPDATE);
    end

    // The final quotient bit is folded in combinationally, so the divider is re-armed
    // for B on the same edge that R's result is captured.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            snap_r <= '0;
            snap_g <= '0;
            snap_b <= '0;
            rem    <= '0;
            num    <= '0;
            cnt    <= '0;
            r_res  <= 20'h01000;
            b_res  <= 20'h01000;
        end else if (start) begin
            snap_r <= sum_r_x;
            snap_g <= sum_g_x;
            snap_b <= sum_b_x;
            rem    <= '0;
            num    <= {sum_g_x, 12'b0};
            cnt    <= '0;
        end else if (div_step) begin
            if (last) begin
                rem <= '0;
                num <= {snap_g, 12'b0};
                cnt <= '0;
                if (state == DIV_R)
                    r_res <= gain_of(quo_nx, snap_r, snap_g);
                else
                    b_res <= gain_of(quo_nx, snap_b, snap_g);
            end else begin
                rem <= rem_nx;
                num <= quo_nx;
                cnt <= cnt + 6'd1;
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            pend          <= 1'b0;
            O_r_gain      <= 20'h01000;
            O_b_gain      <= 20'h01000;
            O_gain_update <= 1'b0;
            O_busy        <= 1'b0;
        end else begin
            pend          <= res_load;
            O_gain_update <= pend;
            if (pend) begin
                O_r_gain <= r_res;
                O_b_gain <= b_res;
            end
            if (start)
                O_busy <= 1'b1;
            else if (pend)
                O_busy <= 1'b0;
        end
    end

    assign O_g_gain = 20'h01000;

endmodule

// File: tb/tb_awb_gain_calc.sv
// Scoreboard bench for awb_gain_calc: directed frames push expected gains,
// a forked monitor pops and compares on every O_gain_update pulse.
module tb_awb_gain_calc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        fs, fe, valid;
    logic [95:0] data;
    logic [19:0] r_gain, g_gain, b_gain;
    logic        gain_update, busy;

    typedef struct {
        logic [19:0] r;
        logic [19:0] b;
        int          sample;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    awb_gain_calc #(.GAIN_MAX(20'h04000), .GAIN_MIN(20'h00400)) dut (
        .I_clk                (clk),
        .I_rst_n              (rst_n),
        .I_enable             (enable),
        .I_rgb888_frame_start (fs),
        .I_rgb888_frame_end   (fe),
        .I_rgb888_valid       (valid),
        .I_rgb888_data        (data),
        .O_r_gain             (r_gain),
        .O_g_gain             (g_gain),
        .O_b_gain             (b_gain),
        .O_gain_update        (gain_update),
        .O_busy               (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [43:0] act, input logic [43:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && gain_update) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_update", 44'd1, 44'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("r_gain", {24'b0, r_gain}, {24'b0, e.r});
                    chk("g_gain", {24'b0, g_gain}, 44'h01000);
                    chk("b_gain", {24'b0, b_gain}, {24'b0, e.b});
                    chk("latency", 44'(cyc - e.sample), 44'd90);
                    chk("busy_at_update", {43'b0, busy}, 44'd0);
                end
            end
        end
    endtask

    // Beat 0 carries frame_start; frame_end follows in its own cycle without data.
    task automatic send_frame(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                              input int nb, input bit push,
                              input logic [19:0] er, input logic [19:0] eb);
        exp_t e;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            fs    = (i == 0);
            valid = 1'b1;
            data  = {4{r, g, b}};
        end
        @(negedge clk);
        fs    = 1'b0;
        valid = 1'b0;
        data  = '0;
        fe    = 1'b1;
        if (push) begin
            e.r = er;
            e.b = eb;
            e.sample = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        fe = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++)
            @(negedge clk);
        if (exp_q.size() != 0) begin
            chk("update_timeout", 44'(exp_q.size()), 44'd0);
            exp_q.delete();
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        fs     = 1'b0;
        fe     = 1'b0;
        valid  = 1'b0;
        data   = '0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        chk("reset_r_gain", {24'b0, r_gain}, 44'h01000);
        chk("reset_g_gain", {24'b0, g_gain}, 44'h01000);
        chk("reset_b_gain", {24'b0, b_gain}, 44'h01000);
        chk("reset_update", {43'b0, gain_update}, 44'd0);
        chk("reset_busy", {43'b0, busy}, 44'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send_frame(8'd100, 8'd100, 8'd100, 8, 1'b1, 20'h01000, 20'h01000);
        chk("busy_after_start", {43'b0, busy}, 44'd1);
        wait_idle();
        send_frame(8'd50, 8'd100, 8'd200, 8, 1'b1, 20'h02000, 20'h00800);
        wait_idle();
        send_frame(8'd10, 8'd200, 8'd10, 8, 1'b1, 20'h04000, 20'h04000);
        wait_idle();
        send_frame(8'd255, 8'd10, 8'd255, 8, 1'b1, 20'h00400, 20'h00400);
        wait_idle();
        send_frame(8'd0, 8'd100, 8'd0, 8, 1'b1, 20'h04000, 20'h04000);
        wait_idle();
        send_frame(8'd0, 8'd0, 8'd0, 8, 1'b1, 20'h01000, 20'h01000);
        wait_idle();
        send_frame(8'd1, 8'd2, 8'd3, 1, 1'b1, 20'h02000, 20'h00AAA);
        wait_idle();

        // Second frame_end while busy must be dropped.
        send_frame(8'd50, 8'd100, 8'd200, 8, 1'b1, 20'h02000, 20'h00800);
        repeat (19) @(negedge clk);
        chk("busy_mid_division", {43'b0, busy}, 44'd1);
        data  = {4{8'd100, 8'd100, 8'd100}};
        valid = 1'b1;
        fe    = 1'b1;
        @(negedge clk);
        fe    = 1'b0;
        valid = 1'b0;
        wait_idle();
        repeat (120) @(negedge clk);

        enable = 1'b0;
        send_frame(8'd10, 8'd200, 8'd10, 8, 1'b0, 20'h0, 20'h0);
        chk("disabled_busy", {43'b0, busy}, 44'd0);
        @(negedge clk);
        chk("disabled_busy_2", {43'b0, busy}, 44'd0);
        chk("disabled_r_hold", {24'b0, r_gain}, 44'h02000);
        repeat (100) @(negedge clk);
        enable = 1'b1;

        send_frame(8'd10, 8'd200, 8'd10, 8, 1'b0, 20'h0, 20'h0);
        repeat (50) @(negedge clk);
        chk("busy_before_reset", {43'b0, busy}, 44'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_r_gain", {24'b0, r_gain}, 44'h01000);
        chk("abort_b_gain", {24'b0, b_gain}, 44'h01000);
        chk("abort_busy", {43'b0, busy}, 44'd0);
        chk("abort_update", {43'b0, gain_update}, 44'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (120) @(negedge clk);
        chk("final_r_gain", {24'b0, r_gain}, 44'h01000);
        chk("scoreboard_empty", 44'(exp_q.size()), 44'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
